ssrv_ahb_mem: RTL and testbench
===============================

Name: ssrv_ahb_mem

Overview:
- Parametrised dual-port AHB-Lite slave memory for FPGA and simulation test of the SSRV/SCR1 core. It replaces the fixed 64 KiB vendor dual RAM with an inferred array of configurable width and depth.
- Instruction port: read-only. Data port: read/write, byte-lane writes.
- New versus previous generation:
  - Write-to-read forwarding instead of a collision stall.
  - Programmable wait states per port.
  - Two-cycle AHB ERROR response for out-of-range, misaligned or illegal transfers.

Parameters:
- AHB_WIDTH, 32, bus data/address width. Only 32 is supported; data lanes are 4 bytes.
- MEM_ABITS, 16, log2 of memory size in bytes. Array depth is 2^(MEM_ABITS-2) words.
- BASE_ADDR, 32'h0, byte base address. Must be aligned to 2^MEM_ABITS.
- IMEM_WAIT, 0, wait states inserted per instruction-port transfer (0..7).
- DMEM_WAIT, 0, wait states inserted per data-port transfer (0..7).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- imem_htrans  in  2  AHB transfer type; bit1=NONSEQ/SEQ
- imem_hsize  in  3  transfer size
- imem_haddr  in  AHB_WIDTH  byte address
- imem_hready  out  1  transfer done / slave ready
- imem_hrdata  out  AHB_WIDTH  read data
- imem_hresp  out  1  1=ERROR
- dmem_htrans  in  2  AHB transfer type
- dmem_hsize  in  3  transfer size
- dmem_haddr  in  AHB_WIDTH  byte address
- dmem_hwrite  in  1  1=write
- dmem_hwdata  in  AHB_WIDTH  write data, valid in data phase
- dmem_hready  out  1  transfer done / slave ready
- dmem_hrdata  out  AHB_WIDTH  read data
- dmem_hresp  out  1  1=ERROR

Behaviour:
- Reset: every output holds these values in the cycle after rst is sampled high: hready=1, hresp=0, hrdata=0, all phase registers idle, wait counters 0. Memory contents are not cleared. Reset mid-transfer abandons the transfer; a pending write is not committed.
- Each port runs an independent FSM with states IDLE, WAIT, DATA, ERR1, ERR2.
- Acceptance: a transfer is accepted when htrans[1]=1 and hready=1. Address-phase fields are registered at acceptance.
- Legality check at acceptance. The transfer is illegal if any of:
  - haddr is outside [BASE_ADDR, BASE_ADDR+2^MEM_ABITS)
  - hsize>2
  - halfword address with haddr[0]=1
  - word address with haddr[1:0]!=0
  - a write on the imem port (there is no imem_hwrite, so this cannot occur; imem legality is range and size only).
- Illegal transfer: ERR1 drives hready=0, hresp=1. ERR2 drives hready=1, hresp=1. The FSM then returns to IDLE or accepts the next transfer. No memory access takes place.
- Legal transfer with WAIT=N:
  - N>0: N cycles in WAIT with hready=0, hresp=0, then one DATA cycle with hready=1.
  - N=0: the data phase completes in the cycle after acceptance, with hready=1.
- The RAM read is issued in the last WAIT cycle, or at acceptance when N=0. Read data is registered and presented during the DATA cycle.
- Read data lane replication, keyed by registered {hsize, haddr[1:0]}:
  - byte: selected byte replicated into all 4 lanes
  - halfword: selected half replicated into both halves
  - word: unchanged
- Writes:
  - hwdata is sampled in the DATA cycle, when hready=1.
  - The write commits on that clock edge.
  - Byte enables: byte = 1<<a[1:0]; half = 2'b11<<(2*a[1]); word = 4'b1111.
- Forwarding:
  - Case: a read whose RAM access coincides with a committing dmem write to the same word index (back-to-back pipelined W then R).
  - The read data is merged per byte: enabled bytes come from hwdata, other bytes from the RAM.
  - No stall; dmem_hready stays 1 when DMEM_WAIT=0.
- Cross-port access: an imem read of the word being written in the same cycle returns old data. This is defined behaviour and is not forwarded.
- hrdata outside a read DATA cycle holds its last value.
- Pipelining: the address of the next transfer may be accepted in the DATA cycle of the current one. Sustained throughput is 1 transfer/cycle at WAIT=0.

Test Plan:
- Reset, then a dmem word write of 32'hDEADBEEF @0x10, then an imem read @0x10 → imem_hrdata=32'hDEADBEEF, hready=1, hresp=0.
- Back-to-back dmem: write byte 8'hA5 @0x21, then read word @0x20 in the next address phase, with prior content 32'h11223344 → hrdata=32'h1122A544 with no stall cycle.
- dmem half read @0x22 of word 32'hCAFEF00D → hrdata=32'hCAFECAFE. Byte read @0x23 → 32'hCACACACA.
- DMEM_WAIT=2, word read → hready low exactly 2 cycles, then data with hready=1.
- Read @BASE_ADDR+2^MEM_ABITS → hready=0,hresp=1, then hready=1,hresp=1. Misaligned word @0x2 → same. Memory unchanged.
- Assert rst in a WAIT cycle of a write → next cycle hready=1, hresp=0; the target word still holds its old value.

Source files
------------

// File: rtl/ssrv_ahb_mem_if.sv
`default_nettype none
//==========================================================================
// Module   : ssrv_ahb_mem_if
// Brief    : AHB-Lite transfer signals for one slave port of ssrv_ahb_mem.
//            The instruction port leaves hwrite/hwdata undriven by the
//            master side (tie them to zero).
// Revision : 1.0 - initial release
//==========================================================================
interface ssrv_ahb_mem_if #(
  parameter int AHB_WIDTH = 32
) ();
  logic [1:0]           htrans;
  logic [2:0]           hsize;
  logic [AHB_WIDTH-1:0] haddr;
  logic                 hwrite;
  logic [AHB_WIDTH-1:0] hwdata;
  logic                 hready;
  logic [AHB_WIDTH-1:0] hrdata;
  logic                 hresp;

  modport master (
    output htrans, hsize, haddr, hwrite, hwdata,
    input  hready, hrdata, hresp
  );

  modport slave (
    input  htrans, hsize, haddr, hwrite, hwdata,
    output hready, hrdata, hresp
  );
endinterface

`default_nettype wire

// File: rtl/ssrv_ahb_mem.sv
`default_nettype none
//==========================================================================
// Module   : ssrv_ahb_mem
// Brief    : Dual-port AHB-Lite slave memory. Read-only instruction port,
//            read/write data port with byte lanes, per-port wait states,
//            two-cycle ERROR response and dmem write-to-read forwarding.
// Revision : 1.0 - initial release
//==========================================================================
module ssrv_ahb_mem #(
  parameter int                   AHB_WIDTH = 32,
  parameter int                   MEM_ABITS = 16,
  parameter logic [AHB_WIDTH-1:0] BASE_ADDR = '0,
  parameter int                   IMEM_WAIT = 0,
  parameter int                   DMEM_WAIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  ssrv_ahb_mem_if.slave imem,
  ssrv_ahb_mem_if.slave dmem
);

  localparam int         c_iw        = MEM_ABITS - 2;
  localparam int         c_depth     = 2 ** c_iw;
  localparam logic [2:0] c_i_wait_ld = 3'(IMEM_WAIT - 1);
  localparam logic [2:0] c_d_wait_ld = 3'(DMEM_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Address lies inside the window; BASE_ADDR is aligned to the window size
  function automatic logic in_range(input logic [AHB_WIDTH-1:0] a);
    return a[AHB_WIDTH-1:MEM_ABITS] == BASE_ADDR[AHB_WIDTH-1:MEM_ABITS];
  endfunction

  // Replicate the addressed byte/half into every lane of the read word
  function automatic logic [31:0] lane_rep(input logic [31:0] w,
                                           input logic [2:0]  sz,
                                           input logic [1:0]  a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      3'd0:    r = {4{b}};
      3'd1:    r = {2{h}};
      default: r = w;
    endcase
    return r;
  endfunction

  // Byte enables of a write from its size and low address bits
  function automatic logic [3:0] byte_en(input logic [2:0] sz,
                                         input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      3'd0:    be = 4'b0001 << a;
      3'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  logic [31:0] r_mem [c_depth];

  //------------------------------------------------------------------------
  // Instruction port
  //------------------------------------------------------------------------
  state_t               r_i_state, w_i_state_nx;
  logic [2:0]           r_i_cnt, w_i_cnt_nx;
  logic                 w_i_hready, w_i_hresp, w_i_accept, w_i_legal;
  logic [MEM_ABITS-1:0] r_i_addr;
  logic [2:0]           r_i_size;
  logic                 w_i_rd_issue;
  logic [MEM_ABITS-1:0] w_i_rd_addr;
  logic [2:0]           w_i_rd_size;
  logic [31:0]          r_i_ram;
  logic [4:0]           r_i_sel;
  logic                 w_unused_imem;

  // imem has no write strobe; only range and size decide legality
  assign w_i_legal     = in_range(imem.haddr) && (imem.hsize <= 3'd2);
  assign w_unused_imem = ^{imem.hwrite, imem.hwdata};

  // imem state and wait-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_state <= ST_IDLE;
      r_i_cnt   <= 3'd0;
    end else begin
      r_i_state <= w_i_state_nx;
      r_i_cnt   <= w_i_cnt_nx;
    end
  end

  // imem next state, handshake outputs and acceptance
  always_comb begin
    w_i_state_nx = r_i_state;
    w_i_cnt_nx   = r_i_cnt;
    w_i_hready   = 1'b1;
    w_i_hresp    = 1'b0;
    w_i_accept   = 1'b0;
    case (r_i_state)
      ST_WAIT: begin
        w_i_hready = 1'b0;
        if (r_i_cnt == 3'd0) w_i_state_nx = ST_DATA;
        else                 w_i_cnt_nx   = r_i_cnt - 3'd1;
      end
      ST_ERR1: begin
        w_i_hready   = 1'b0;
        w_i_hresp    = 1'b1;
        w_i_state_nx = ST_ERR2;
      end
      ST_ERR2: w_i_hresp = 1'b1;
      default: ;
    endcase
    if (w_i_hready) begin
      w_i_accept = imem.htrans[1];
      if (!imem.htrans[1]) begin
        w_i_state_nx = ST_IDLE;
      end else if (!w_i_legal) begin
        w_i_state_nx = ST_ERR1;
      end else if (IMEM_WAIT != 0) begin
        w_i_state_nx = ST_WAIT;
        w_i_cnt_nx   = c_i_wait_ld;
      end else begin
        w_i_state_nx = ST_DATA;
      end
    end
  end

  // imem address-phase capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_addr <= '0;
      r_i_size <= 3'd0;
    end else if (w_i_accept) begin
      r_i_addr <= imem.haddr[MEM_ABITS-1:0];
      r_i_size <= imem.hsize;
    end
  end

  // RAM read happens at acceptance (no wait) or in the last wait cycle
  assign w_i_rd_issue = (w_i_accept && w_i_legal && (IMEM_WAIT == 0)) ||
                        (r_i_state == ST_WAIT && r_i_cnt == 3'd0);
  assign w_i_rd_addr  = (r_i_state == ST_WAIT) ? r_i_addr : imem.haddr[MEM_ABITS-1:0];
  assign w_i_rd_size  = (r_i_state == ST_WAIT) ? r_i_size : imem.hsize;

  // imem read data register; holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_ram <= 32'd0;
      r_i_sel <= 5'd0;
    end else if (w_i_rd_issue) begin
      r_i_ram <= r_mem[w_i_rd_addr[MEM_ABITS-1:2]];
      r_i_sel <= {w_i_rd_size, w_i_rd_addr[1:0]};
    end
  end

  assign imem.hready = w_i_hready;
  assign imem.hresp  = w_i_hresp;
  assign imem.hrdata = lane_rep(r_i_ram, r_i_sel[4:2], r_i_sel[1:0]);

  //------------------------------------------------------------------------
  // Data port
  //------------------------------------------------------------------------
  state_t               r_d_state, w_d_state_nx;
  logic [2:0]           r_d_cnt, w_d_cnt_nx;
  logic                 w_d_hready, w_d_hresp, w_d_accept, w_d_legal;
  logic [MEM_ABITS-1:0] r_d_addr;
  logic [2:0]           r_d_size;
  logic                 r_d_write;
  logic                 w_d_rd_issue, w_d_wr_en;
  logic [MEM_ABITS-1:0] w_d_rd_addr;
  logic [2:0]           w_d_rd_size;
  logic [c_iw-1:0]      w_d_wr_idx;
  logic [3:0]           w_d_be, w_d_fwd_be;
  logic [31:0]          r_d_ram, r_d_fwd_data, w_d_merged;
  logic [3:0]           r_d_fwd_be;
  logic [4:0]           r_d_sel;

  assign w_d_legal = in_range(dmem.haddr) && (dmem.hsize <= 3'd2) &&
                     !(dmem.hsize == 3'd1 && dmem.haddr[0]) &&
                     !(dmem.hsize == 3'd2 && dmem.haddr[1:0] != 2'd0);

  // dmem state and wait-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_state <= ST_IDLE;
      r_d_cnt   <= 3'd0;
    end else begin
      r_d_state <= w_d_state_nx;
      r_d_cnt   <= w_d_cnt_nx;
    end
  end

  // dmem next state, handshake outputs and acceptance
  always_comb begin
    w_d_state_nx = r_d_state;
    w_d_cnt_nx   = r_d_cnt;
    w_d_hready   = 1'b1;
    w_d_hresp    = 1'b0;
    w_d_accept   = 1'b0;
    case (r_d_state)
      ST_WAIT: begin
        w_d_hready = 1'b0;
        if (r_d_cnt == 3'd0) w_d_state_nx = ST_DATA;
        else                 w_d_cnt_nx   = r_d_cnt - 3'd1;
      end
      ST_ERR1: begin
        w_d_hready   = 1'b0;
        w_d_hresp    = 1'b1;
        w_d_state_nx = ST_ERR2;
      end
      ST_ERR2: w_d_hresp = 1'b1;
      default: ;
    endcase
    if (w_d_hready) begin
      w_d_accept = dmem.htrans[1];
      if (!dmem.htrans[1]) begin
        w_d_state_nx = ST_IDLE;
      end else if (!w_d_legal) begin
        w_d_state_nx = ST_ERR1;
      end else if (DMEM_WAIT != 0) begin
        w_d_state_nx = ST_WAIT;
        w_d_cnt_nx   = c_d_wait_ld;
      end else begin
        w_d_state_nx = ST_DATA;
      end
    end
  end

  // dmem address-phase capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_addr  <= '0;
      r_d_size  <= 3'd0;
      r_d_write <= 1'b0;
    end else if (w_d_accept) begin
      r_d_addr  <= dmem.haddr[MEM_ABITS-1:0];
      r_d_size  <= dmem.hsize;
      r_d_write <= dmem.hwrite;
    end
  end

  // Write commits at the end of its data cycle; hwdata is valid then
  assign w_d_wr_en  = (r_d_state == ST_DATA) && r_d_write && !rst;
  assign w_d_wr_idx = r_d_addr[MEM_ABITS-1:2];
  assign w_d_be     = byte_en(r_d_size, r_d_addr[1:0]);

  assign w_d_rd_issue = (w_d_accept && w_d_legal && !dmem.hwrite && (DMEM_WAIT == 0)) ||
                        (r_d_state == ST_WAIT && r_d_cnt == 3'd0 && !r_d_write);
  assign w_d_rd_addr  = (r_d_state == ST_WAIT) ? r_d_addr : dmem.haddr[MEM_ABITS-1:0];
  assign w_d_rd_size  = (r_d_state == ST_WAIT) ? r_d_size : dmem.hsize;

  // A read issued on the edge a same-word write commits takes written bytes
  assign w_d_fwd_be = (w_d_wr_en && w_d_rd_addr[MEM_ABITS-1:2] == w_d_wr_idx) ? w_d_be : 4'b0000;

  // Byte-lane RAM write from the data port
  always_ff @(posedge clk) begin
    if (w_d_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_d_be[b]) r_mem[w_d_wr_idx][8*b +: 8] <= dmem.hwdata[8*b +: 8];
      end
    end
  end

  // dmem read data register plus forwarded bytes; holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_ram      <= 32'd0;
      r_d_fwd_be   <= 4'd0;
      r_d_fwd_data <= 32'd0;
      r_d_sel      <= 5'd0;
    end else if (w_d_rd_issue) begin
      r_d_ram      <= r_mem[w_d_rd_addr[MEM_ABITS-1:2]];
      r_d_fwd_be   <= w_d_fwd_be;
      r_d_fwd_data <= dmem.hwdata;
      r_d_sel      <= {w_d_rd_size, w_d_rd_addr[1:0]};
    end
  end

  // Per-byte merge of forwarded write data over the RAM word
  always_comb begin
    w_d_merged = r_d_ram;
    for (int b = 0; b < 4; b++) begin
      if (r_d_fwd_be[b]) w_d_merged[8*b +: 8] = r_d_fwd_data[8*b +: 8];
    end
  end

  assign dmem.hready = w_d_hready;
  assign dmem.hresp  = w_d_hresp;
  assign dmem.hrdata = lane_rep(w_d_merged, r_d_sel[4:2], r_d_sel[1:0]);

endmodule

`default_nettype wire

// File: tb/tb_ssrv_ahb_mem.sv
`default_nettype none
//==========================================================================
// Module   : tb_ssrv_ahb_mem
// Brief    : Directed, table-driven bench for ssrv_ahb_mem. dut0 has no
//            wait states, dut1 has DMEM_WAIT=2 and IMEM_WAIT=1.
//            Port ids: 0=dut0 dmem, 1=dut0 imem, 2=dut1 dmem, 3=dut1 imem.
// Revision : 1.0 - initial release
//==========================================================================
module tb_ssrv_ahb_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ssrv_ahb_mem_if i0 ();
  ssrv_ahb_mem_if d0 ();
  ssrv_ahb_mem_if i1 ();
  ssrv_ahb_mem_if d1 ();

  ssrv_ahb_mem dut0 (.clk(clk), .rst(rst), .imem(i0), .dmem(d0));

  ssrv_ahb_mem #(.DMEM_WAIT(2), .IMEM_WAIT(1)) dut1 (
    .clk(clk), .rst(rst), .imem(i1), .dmem(d1)
  );

  typedef struct packed {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input int p, input logic [1:0] tr, input logic [2:0] sz,
                     input logic [31:0] a, input logic wr, input logic [31:0] wd);
    case (p)
      0: begin d0.htrans = tr; d0.hsize = sz; d0.haddr = a; d0.hwrite = wr; d0.hwdata = wd; end
      1: begin i0.htrans = tr; i0.hsize = sz; i0.haddr = a; end
      2: begin d1.htrans = tr; d1.hsize = sz; d1.haddr = a; d1.hwrite = wr; d1.hwdata = wd; end
      default: begin i1.htrans = tr; i1.hsize = sz; i1.haddr = a; end
    endcase
  endtask

  task automatic samp(input int p, output logic [31:0] rd, output logic rdy, output logic rsp);
    case (p)
      0: begin rd = d0.hrdata; rdy = d0.hready; rsp = d0.hresp; end
      1: begin rd = i0.hrdata; rdy = i0.hready; rsp = i0.hresp; end
      2: begin rd = d1.hrdata; rdy = d1.hready; rsp = d1.hresp; end
      default: begin rd = i1.hrdata; rdy = i1.hready; rsp = i1.hresp; end
    endcase
  endtask

  // Single non-pipelined transfer; counts data-phase cycles with hready=0
  task automatic xfer(input int p, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic f_rdy, output logic f_rsp,
                      output logic l_rsp, output int waits);
    logic rdy, rsp;
    @(negedge clk);
    drv(p, 2'b10, sz, a, wr, 32'd0);
    @(negedge clk);
    drv(p, 2'b00, 3'd0, 32'd0, 1'b0, wd);
    samp(p, rd, rdy, rsp);
    f_rdy = rdy;
    f_rsp = rsp;
    waits = 0;
    while (!rdy && waits < 16) begin
      @(negedge clk);
      waits++;
      samp(p, rd, rdy, rsp);
    end
    l_rsp = rsp;
  endtask

  task automatic check_xfer(input string nm, input int p, input logic wr, input logic [2:0] sz,
                            input logic [31:0] a, input logic [31:0] wd, input logic err,
                            input logic chk_rd, input logic [31:0] exp_rd, input int exp_waits);
    logic [31:0] rd;
    logic        f_rdy, f_rsp, l_rsp;
    int          waits;
    xfer(p, wr, sz, a, wd, rd, f_rdy, f_rsp, l_rsp, waits);
    chk({nm, "_rdy0"},  32'(f_rdy), 32'(exp_waits == 0));
    chk({nm, "_resp0"}, 32'(f_rsp), 32'(err));
    chk({nm, "_resp"},  32'(l_rsp), 32'(err));
    chk({nm, "_waits"}, 32'(waits), 32'(exp_waits));
    if (chk_rd) chk({nm, "_rdata"}, rd, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        rdy, rsp;

    vecs[0]  = '{1'b1, 3'd2, 32'h30,    32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'd1, 32'h32,    32'h0,        1'b0, 1'b1, 32'hCAFECAFE};
    vecs[2]  = '{1'b0, 3'd0, 32'h33,    32'h0,        1'b0, 1'b1, 32'hCACACACA};
    vecs[3]  = '{1'b0, 3'd0, 32'h30,    32'h0,        1'b0, 1'b1, 32'h0D0D0D0D};
    vecs[4]  = '{1'b0, 3'd1, 32'h30,    32'h0,        1'b0, 1'b1, 32'hF00DF00D};
    vecs[5]  = '{1'b1, 3'd1, 32'h32,    32'h12345678, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 3'd2, 32'h30,    32'h0,        1'b0, 1'b1, 32'h1234F00D};
    vecs[7]  = '{1'b1, 3'd0, 32'h31,    32'hFFFFABFF, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 3'd2, 32'h30,    32'h0,        1'b0, 1'b1, 32'h1234AB0D};
    vecs[9]  = '{1'b0, 3'd2, 32'h10000, 32'h0,        1'b1, 1'b1, 32'h1234AB0D};
    vecs[10] = '{1'b0, 3'd2, 32'h2,     32'h0,        1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 3'd1, 32'h31,    32'h0,        1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 3'd3, 32'h30,    32'h0,        1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 3'd2, 32'h32,    32'h0,        1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 3'd2, 32'h30,    32'h0,        1'b0, 1'b1, 32'h1234AB0D};
    vecs[15] = '{1'b1, 3'd2, 32'hFFFC,  32'h01020304, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 3'd0, 32'hFFFE,  32'h0,        1'b0, 1'b1, 32'h02020202};
    vecs[17] = '{1'b1, 3'd2, 32'h0,     32'h0BADF00D, 1'b0, 1'b0, 32'h0};
    vecs[18] = '{1'b1, 3'd2, 32'h10000, 32'h99999999, 1'b1, 1'b0, 32'h0};
    vecs[19] = '{1'b0, 3'd2, 32'h0,     32'h0,        1'b0, 1'b1, 32'h0BADF00D};

    for (int p = 0; p < 4; p++) drv(p, 2'b00, 3'd0, 32'd0, 1'b0, 32'd0);
    i0.hwrite = 1'b0; i0.hwdata = 32'd0;
    i1.hwrite = 1'b0; i1.hwdata = 32'd0;

    // Reset state on every port
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      samp(p, rd, rdy, rsp);
      chk($sformatf("rst_p%0d_hready", p), 32'(rdy), 32'd1);
      chk($sformatf("rst_p%0d_hresp", p),  32'(rsp), 32'd0);
      chk($sformatf("rst_p%0d_hrdata", p), rd, 32'd0);
    end
    rst = 1'b0;

    // dmem write, then imem read of the same word
    check_xfer("wr10", 0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 0);
    check_xfer("ird10", 1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 0);
    check_xfer("ioor", 1, 1'b0, 3'd2, 32'h10004, 32'h0, 1'b1, 1'b0, 32'h0, 1);

    // Table of single transfers on dut0 dmem
    for (int k = 0; k < 20; k++) begin
      check_xfer($sformatf("vec%0d", k), 0, vecs[k].wr, vecs[k].sz, vecs[k].a, vecs[k].wd,
                 vecs[k].err, vecs[k].chk_rd, vecs[k].exp_rd, vecs[k].err ? 1 : 0);
    end

    // Back-to-back byte write then word read of the same word: forwarded
    check_xfer("fwd_pre", 0, 1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0, 1'b0, 32'h0, 0);
    @(negedge clk);
    drv(0, 2'b10, 3'd0, 32'h21, 1'b1, 32'd0);
    @(negedge clk);
    drv(0, 2'b10, 3'd2, 32'h20, 1'b0, 32'h7766A555);
    samp(0, rd, rdy, rsp);
    chk("fwd_wr_hready", 32'(rdy), 32'd1);
    @(negedge clk);
    drv(0, 2'b00, 3'd0, 32'd0, 1'b0, 32'd0);
    samp(0, rd, rdy, rsp);
    chk("fwd_rd_hready", 32'(rdy), 32'd1);
    chk("fwd_rd_hresp",  32'(rsp), 32'd0);
    chk("fwd_rd_hrdata", rd, 32'h1122A544);
    check_xfer("fwd_post", 0, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 1'b1, 32'h1122A544, 0);

    // imem read colliding with a committing dmem write sees old data
    check_xfer("xp_pre", 0, 1'b1, 3'd2, 32'h40, 32'hAAAAAAAA, 1'b0, 1'b0, 32'h0, 0);
    @(negedge clk);
    drv(0, 2'b10, 3'd2, 32'h40, 1'b1, 32'd0);
    @(negedge clk);
    drv(0, 2'b00, 3'd0, 32'd0, 1'b0, 32'h55555555);
    drv(1, 2'b10, 3'd2, 32'h40, 1'b0, 32'd0);
    @(negedge clk);
    drv(1, 2'b00, 3'd0, 32'd0, 1'b0, 32'd0);
    samp(1, rd, rdy, rsp);
    chk("xp_rd_hready", 32'(rdy), 32'd1);
    chk("xp_rd_hrdata", rd, 32'hAAAAAAAA);
    check_xfer("xp_post", 1, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 1'b1, 32'h55555555, 0);

    // Wait states on dut1
    check_xfer("w2_wr", 2, 1'b1, 3'd2, 32'h50, 32'h13572468, 1'b0, 1'b0, 32'h0, 2);
    check_xfer("w2_rd", 2, 1'b0, 3'd2, 32'h50, 32'h0, 1'b0, 1'b1, 32'h13572468, 2);
    check_xfer("w1_ird", 3, 1'b0, 3'd1, 32'h52, 32'h0, 1'b0, 1'b1, 32'h13571357, 1);
    check_xfer("w2_err", 2, 1'b0, 3'd2, 32'h2, 32'h0, 1'b1, 1'b0, 32'h0, 1);

    // Reset during a wait cycle of a write abandons it
    @(negedge clk);
    drv(2, 2'b10, 3'd2, 32'h50, 1'b1, 32'd0);
    @(negedge clk);
    drv(2, 2'b00, 3'd0, 32'd0, 1'b0, 32'hFFFFFFFF);
    samp(2, rd, rdy, rsp);
    chk("rstw_in_wait", 32'(rdy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    samp(2, rd, rdy, rsp);
    chk("rstw_hready", 32'(rdy), 32'd1);
    chk("rstw_hresp",  32'(rsp), 32'd0);
    chk("rstw_hrdata", rd, 32'd0);
    check_xfer("rstw_rd", 2, 1'b0, 3'd2, 32'h50, 32'h0, 1'b0, 1'b1, 32'h13572468, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
